// File: rtl/uart_pkg.sv
// Shared definitions for the UART port-bus echo master: status bit positions,
// default port addresses and the service FSM state encoding.
package uart_pkg;

  localparam int RX_RDY_BIT = 0;
  localparam int TX_RDY_BIT = 1;
  localparam int PERR_BIT   = 2;
  localparam int FERR_BIT   = 3;
  localparam int OVF_BIT    = 4;

  localparam logic [15:0] DATA_PORT_DEF   = 16'h0000;
  localparam logic [15:0] STATUS_PORT_DEF = 16'h0001;
  localparam logic [15:0] LED_PORT_DEF    = 16'h0002;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    RD_STAT = 3'd2,
    DECIDE  = 3'd3,
    RD_DATA = 3'd4,
    WR_DATA = 3'd5,
    WR_LED  = 3'd6
  } state_t;

endpackage

// File: rtl/echo_fifo.sv
// Small synchronous FIFO holding received bytes until they are echoed.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Push while full and pop while empty are ignored.
module echo_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_out,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_echo_master.sv
// Port-bus initiator that services the UART interrupt in place of firmware:
// reads status and data, buffers received bytes, echoes one byte per pass and
// writes {err_count, rx_count} to the LED port.
// Build option: define ECHO_ERR_FILTER_EN to drop bytes flagged with
// parity or framing errors instead of echoing them.
module uart_echo_master
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DATA_PORT   = DATA_PORT_DEF,
  parameter logic [15:0] STATUS_PORT = STATUS_PORT_DEF,
  parameter logic [15:0] LED_PORT    = LED_PORT_DEF
) (
  input  logic        clk,
  input  logic        rst_out,
  input  logic        interrupt,
  input  logic [15:0] in_port,
  output logic [15:0] port_id,
  output logic [15:0] out_port,
  output logic        read_strobe,
  output logic        write_strobe,
  output logic        interrupt_ack
);

  state_t      state_q, state_d;
  logic [7:0]  stat_q;
  logic [7:0]  rx_count_q, rx_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head, tx_byte;
  logic        in_rd, rx_err, byte_bad, drop;
  logic [15:0] port_id_d, out_port_d;
  logic        read_strobe_d, write_strobe_d, interrupt_ack_d;
  logic        unused_in_hi;

  assign unused_in_hi = ^in_port[15:8];

  assign in_rd  = (state_q == RD_DATA);
  assign rx_err = |stat_q[OVF_BIT:PERR_BIT];
`ifdef ECHO_ERR_FILTER_EN
  assign byte_bad = stat_q[PERR_BIT] | stat_q[FERR_BIT];
`else
  assign byte_bad = 1'b0;
`endif
  assign fifo_push = in_rd && !fifo_full && !byte_bad;
  assign drop      = in_rd && fifo_full && !byte_bad;
  assign fifo_pop  = (state_q == WR_DATA);

  // When the FIFO is empty on the way into WR_DATA, the byte is being pushed
  // this very cycle, so forward it straight from the bus.
  assign tx_byte = fifo_empty ? in_port[7:0] : fifo_head;

  echo_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk   (clk),
    .rst_out(rst_out),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_port[7:0]),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic for one service pass.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (interrupt) state_d = ACK;
      ACK:     state_d = RD_STAT;
      RD_STAT: state_d = DECIDE;
      DECIDE: begin
        if (stat_q[RX_RDY_BIT])                     state_d = RD_DATA;
        else if (stat_q[TX_RDY_BIT] && !fifo_empty) state_d = WR_DATA;
        else                                        state_d = WR_LED;
      end
      RD_DATA: begin
        if (stat_q[TX_RDY_BIT] && (fifo_push || !fifo_empty)) state_d = WR_DATA;
        else                                                  state_d = WR_LED;
      end
      WR_DATA: state_d = WR_LED;
      WR_LED:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter updates happen on the RD_DATA edge; the LED write uses these.
  always_comb begin
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    if (in_rd) begin
      rx_count_d = rx_count_q + 8'd1;
      if ((rx_err || drop) && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end
  end

  // Bus outputs for the state being entered, so they are registered.
  always_comb begin
    port_id_d       = 16'h0000;
    out_port_d      = 16'h0000;
    read_strobe_d   = 1'b0;
    write_strobe_d  = 1'b0;
    interrupt_ack_d = 1'b0;
    unique case (state_d)
      ACK:     interrupt_ack_d = 1'b1;
      RD_STAT: begin port_id_d = STATUS_PORT; read_strobe_d = 1'b1; end
      RD_DATA: begin port_id_d = DATA_PORT;   read_strobe_d = 1'b1; end
      WR_DATA: begin
        port_id_d      = DATA_PORT;
        out_port_d     = {8'h00, tx_byte};
        write_strobe_d = 1'b1;
      end
      WR_LED: begin
        port_id_d      = LED_PORT;
        out_port_d     = {err_count_d, rx_count_d};
        write_strobe_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered bus outputs, status capture and counters.
  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) begin
      port_id       <= '0;
      out_port      <= '0;
      read_strobe   <= 1'b0;
      write_strobe  <= 1'b0;
      interrupt_ack <= 1'b0;
      stat_q        <= '0;
      rx_count_q    <= '0;
      err_count_q   <= '0;
    end else begin
      port_id       <= port_id_d;
      out_port      <= out_port_d;
      read_strobe   <= read_strobe_d;
      write_strobe  <= write_strobe_d;
      interrupt_ack <= interrupt_ack_d;
      if (state_q == RD_STAT) stat_q <= in_port[7:0];
      rx_count_q    <= rx_count_d;
      err_count_q   <= err_count_d;
    end
  end

endmodule

// File: tb/tb_uart_echo_master.sv
// Scoreboard bench for uart_echo_master: a bus-slave model answers reads,
// expected bus transactions are queued per pass and a monitor checks them.
module tb_uart_echo_master;

  localparam logic [15:0] DP = 16'h0000;
  localparam logic [15:0] SP = 16'h0001;
  localparam logic [15:0] LP = 16'h0002;

  logic        clk = 1'b0;
  logic        rst_out = 1'b1;
  logic        interrupt = 1'b0;
  logic [15:0] in_port;
  logic [15:0] port_id, out_port;
  logic        read_strobe, write_strobe, interrupt_ack;

  logic [7:0]  stat_v = 8'h00;
  logic [7:0]  data_v = 8'h00;

  logic [31:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign in_port = (port_id == SP) ? {8'h00, stat_v} :
                   (port_id == DP) ? {8'h00, data_v} : 16'h0000;

  uart_echo_master dut (
    .clk          (clk),
    .rst_out      (rst_out),
    .interrupt    (interrupt),
    .in_port      (in_port),
    .port_id      (port_id),
    .out_port     (out_port),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .interrupt_ack(interrupt_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every bus transaction against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst_out && (read_strobe || write_strobe || interrupt_ack)) begin
      check("one_strobe", 32'($countones({read_strobe, write_strobe, interrupt_ack})), 32'd1);
      if (write_strobe) begin
        if (exp_wr.size() == 0) check("unexpected_write", {port_id, out_port}, 32'hFFFF_FFFF);
        else check("write", {port_id, out_port}, exp_wr.pop_front());
      end
      if (read_strobe) begin
        if (exp_rd.size() == 0) check("unexpected_read", {16'h0, port_id}, 32'hFFFF_FFFF);
        else check("read_port", {16'h0, port_id}, {16'h0, exp_rd.pop_front()});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_out = 1'b1;
    repeat (2) @(negedge clk);
    rst_out = 1'b0;
  endtask

  task automatic idle_zero(input string name);
    check(name, {port_id, out_port}, 32'h0);
    check({name, "_strb"}, {29'h0, read_strobe, write_strobe, interrupt_ack}, 32'h0);
  endtask

  // One service pass; the caller has already queued the expected traffic.
  task automatic do_pass(input logic [7:0] st, input logic [7:0] dt, input int exp_len);
    int cyc;
    bit seen;
    stat_v = st;
    data_v = dt;
    @(negedge clk);
    interrupt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (interrupt_ack) begin seen = 1'b1; break; end
    end
    interrupt = 1'b0;
    check("ack_seen", {31'h0, seen}, 32'd1);
    cyc = 1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cyc++;
      if (write_strobe && port_id == LP) begin seen = 1'b1; break; end
    end
    check("led_seen", {31'h0, seen}, 32'd1);
    check("pass_len", 32'(cyc), 32'(exp_len));
    @(negedge clk);
    idle_zero("post_idle");
  endtask

  initial begin
    bit seen;
    // Reset and idle.
    repeat (2) @(negedge clk);
    idle_zero("in_reset");
    rst_out = 1'b0;
    repeat (3) @(negedge clk);
    idle_zero("idle");

    // Status 03, data 41: full pass with echo.
    exp_rd.push_back(SP); exp_rd.push_back(DP);
    exp_wr.push_back({DP, 16'h0041}); exp_wr.push_back({LP, 16'h0001});
    do_pass(8'h03, 8'h41, 6);

    // Rx without TxRdy, then a Tx-only pass drains the byte.
    do_reset();
    exp_rd.push_back(SP); exp_rd.push_back(DP);
    exp_wr.push_back({LP, 16'h0001});
    do_pass(8'h01, 8'h42, 5);
    exp_rd.push_back(SP);
    exp_wr.push_back({DP, 16'h0042}); exp_wr.push_back({LP, 16'h0001});
    do_pass(8'h02, 8'h00, 5);

    // Fill to overflow: ninth byte dropped and counted as an error.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      exp_rd.push_back(SP); exp_rd.push_back(DP);
      exp_wr.push_back({LP, (k == 9) ? 16'h0109 : 16'(k)});
      do_pass(8'h01, 8'(8'h10 + k), 5);
    end
    exp_rd.push_back(SP);
    exp_wr.push_back({DP, 16'h0011}); exp_wr.push_back({LP, 16'h0109});
    do_pass(8'h02, 8'h00, 5);

    // Parity error flagged with TxRdy.
    do_reset();
    exp_rd.push_back(SP); exp_rd.push_back(DP);
`ifdef ECHO_ERR_FILTER_EN
    exp_wr.push_back({LP, 16'h0101});
    do_pass(8'h07, 8'h55, 5);
`else
    exp_wr.push_back({DP, 16'h0055}); exp_wr.push_back({LP, 16'h0101});
    do_pass(8'h07, 8'h55, 6);
`endif

    // Reset in the middle of RD_DATA.
    do_reset();
    exp_rd.push_back(SP); exp_rd.push_back(DP);
    stat_v = 8'h01;
    data_v = 8'h99;
    @(negedge clk);
    interrupt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (interrupt_ack) interrupt = 1'b0;
      if (read_strobe && port_id == DP) begin seen = 1'b1; break; end
    end
    interrupt = 1'b0;
    check("rd_data_seen", {31'h0, seen}, 32'd1);
    #2;
    rst_out = 1'b1;
    #1;
    check("rst_rd_strobe", {31'h0, read_strobe}, 32'd0);
    check("rst_port_id", {16'h0, port_id}, 32'h0);
    @(negedge clk);
    rst_out = 1'b0;
    exp_rd.push_back(SP);
    exp_wr.push_back({LP, 16'h0000});
    do_pass(8'h02, 8'h00, 4);

    repeat (3) @(negedge clk);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
